// File: rtl/tlp_link_pkg.sv
// Shared link framing constants and scheduler state encoding for the TLP transmit path.
package tlp_link_pkg;
   localparam logic [7:0] STP_SYM = 8'hFB;
   localparam logic [7:0] END_SYM = 8'hFD;
   localparam logic [7:0] EDB_SYM = 8'hFE;
   localparam logic [7:0] IDL_SYM = 8'h00;

   localparam int TLP_BYTES = 20;
   localparam int TLP_W     = 8 * TLP_BYTES;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DATA = 2'd1;
   localparam logic [1:0] TAIL = 2'd2;
endpackage

// File: rtl/tlp_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i; the pointer register lives in the parent.
module tlp_rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  oh_o,
   output logic [PW-1:0] idx_o,
   output logic          vld_o
);
   logic found;

   always_comb begin
      oh_o  = '0;
      idx_o = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req_i[(int'(ptr_i) + k) % N]) begin
            found                          = 1'b1;
            oh_o[(int'(ptr_i) + k) % N]    = 1'b1;
            idx_o                          = PW'((int'(ptr_i) + k) % N);
         end
      end
   end

   assign vld_o = |req_i;
endmodule

// File: rtl/tlp_tx_scheduler.sv
// Round-robin TLP transmit scheduler framing STP / payload / END onto an 8-bit K-flagged link.
// Define TLP_ABORT_EN to let abort replace the next payload byte with EDB and nullify the packet.
module tlp_tx_scheduler #(
   parameter int NUM_REQ   = 2,
   parameter int TLP_BYTES = 20
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*8*TLP_BYTES-1:0] tlp_in,
   input  logic                           abort,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [7:0]                     data_out,
   output logic                           datak,
   output logic                           busy,
   output logic [3:0]                     tx_count
);
   import tlp_link_pkg::*;

   localparam int TW = 8 * TLP_BYTES;
   localparam int CW = $clog2(TLP_BYTES);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [TW-1:0]      sh_q, sh_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [7:0]         data_q, data_d;
   logic               k_q, k_d;
   logic               busy_q, busy_d;
   logic [3:0]         txc_q, txc_d;

   logic [NUM_REQ-1:0] win_oh;
   logic [PW-1:0]      win_idx;
   logic               win_vld;
   logic               abort_hit;

   tlp_rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
      .req_i (req),
      .ptr_i (ptr_q),
      .oh_o  (win_oh),
      .idx_o (win_idx),
      .vld_o (win_vld)
   );

`ifdef TLP_ABORT_EN
   assign abort_hit = abort;
`else
   logic unused_abort;
   assign unused_abort = abort;
   assign abort_hit    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      ptr_d   = ptr_q;
      gnt_d   = '0;
      data_d  = IDL_SYM;
      k_d     = 1'b0;
      busy_d  = 1'b0;
      txc_d   = txc_q;
      case (state_q)
         IDLE: if (win_vld) begin
            sh_d    = tlp_in[win_idx*TW +: TW];
            gnt_d   = win_oh;
            // pointer moves past the winner so it gets lowest priority next time
            ptr_d   = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
            data_d  = STP_SYM;
            k_d     = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = DATA;
         end
         DATA: begin
            busy_d = 1'b1;
            if (abort_hit) begin
               data_d  = EDB_SYM;
               k_d     = 1'b1;
               state_d = IDLE;
            end else begin
               data_d = sh_q[TW-1 -: 8];
               sh_d   = {sh_q[TW-9:0], 8'h00};
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CW'(TLP_BYTES-1)) state_d = TAIL;
            end
         end
         TAIL: begin
            data_d  = END_SYM;
            k_d     = 1'b1;
            busy_d  = 1'b1;
            txc_d   = txc_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         data_q  <= IDL_SYM;
         k_q     <= 1'b0;
         busy_q  <= 1'b0;
         txc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         data_q  <= data_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         txc_q   <= txc_d;
      end
   end

   assign gnt      = gnt_q;
   assign data_out = data_q;
   assign datak    = k_q;
   assign busy     = busy_q;
   assign tx_count = txc_q;
endmodule

// File: tb/tb_tlp_tx_scheduler.sv
// Randomized bench for tlp_tx_scheduler against a frame-queue reference model.
module tb_tlp_tx_scheduler;
   localparam int N  = 2;
   localparam int TB = 20;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req;
   logic [N*160-1:0] tlp_in;
   logic             abort;
   logic [N-1:0]     gnt;
   logic [7:0]       data_out;
   logic             datak;
   logic             busy;
   logic [3:0]       tx_count;

   logic [159:0] src_tlp [N];

   int         n_vec = 0;
   int         n_err = 0;
   logic [8:0] q[$];
   int         last;
   logic [3:0] m_txc;
   logic [N-1:0] m_gnt;

   tlp_tx_scheduler #(.NUM_REQ(N), .TLP_BYTES(TB)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .tlp_in   (tlp_in),
      .abort    (abort),
      .gnt      (gnt),
      .data_out (data_out),
      .datak    (datak),
      .busy     (busy),
      .tx_count (tx_count)
   );

   always #5 clk = ~clk;

   always_comb begin
      tlp_in = '0;
      for (int i = 0; i < N; i++) tlp_in[i*160 +: 160] = src_tlp[i];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [159:0] rnd160();
      logic [159:0] v;
      for (int i = 0; i < 5; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   // Model: whole frames are queued at grant time and one symbol leaves per edge.
   task automatic cycle();
      logic [8:0] sym;
      bit         eb;
      int         w;
      m_gnt = '0;
      if (q.size() == 0 && |req) begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && req[(last + 1 + k) % N]) w = (last + 1 + k) % N;
         last     = w;
         m_gnt[w] = 1'b1;
         q.push_back({1'b1, 8'hFB});
         for (int b = 0; b < TB; b++) q.push_back({1'b0, src_tlp[w][159-8*b -: 8]});
         q.push_back({1'b1, 8'hFD});
      end
`ifdef TLP_ABORT_EN
      if (abort && q.size() >= 2 && q.size() <= TB + 1) begin
         q.delete();
         q.push_back({1'b1, 8'hFE});
      end
`endif
      if (q.size() != 0) begin
         sym = q.pop_front();
         eb  = 1'b1;
         if (sym == {1'b1, 8'hFD}) m_txc = m_txc + 1'b1;
      end else begin
         sym = 9'h000;
         eb  = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("data", data_out, sym[7:0]);
      chk("datak", datak, sym[8]);
      chk("busy", busy, eb);
      chk("gnt", gnt, m_gnt);
      chk("tx_count", tx_count, m_txc);
   endtask

   task automatic upd_req();
      for (int i = 0; i < N; i++) begin
         if (m_gnt[i]) begin
            if ($urandom_range(1, 0) == 1) src_tlp[i] = rnd160();
            else req[i] = 1'b0;
         end else if (!req[i] && $urandom_range(2, 0) == 0) begin
            req[i]     = 1'b1;
            src_tlp[i] = rnd160();
         end
      end
   endtask

   initial begin
      int need;
      reset = 1'b1;
      req   = '0;
      abort = 1'b0;
      for (int i = 0; i < N; i++) src_tlp[i] = '0;
      last  = N - 1;
      m_txc = '0;
      m_gnt = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", data_out, 8'h00);
      chk("rst_k", datak, 1'b0);
      chk("rst_gnt", gnt, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_txc", tx_count, 4'd0);
      reset = 1'b0;
      repeat (3) cycle();

      // single packet
      src_tlp[0] = {32'h11110211, 128'h0};
      req        = 2'b01;
      cycle();
      req = '0;
      repeat (21) cycle();
      chk("single_txc", tx_count, 4'd1);
      repeat (2) cycle();

      // contention: four back-to-back grants
      req = 2'b11;
      src_tlp[0] = rnd160();
      src_tlp[1] = rnd160();
      repeat (4 * 22) begin
         cycle();
         for (int i = 0; i < N; i++) if (m_gnt[i]) src_tlp[i] = rnd160();
      end
      req = '0;
      repeat (25) cycle();

      // reset in the middle of a payload
      req = 2'b11;
      cycle();
      repeat (8) cycle();
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_data", data_out, 8'h00);
      chk("mid_rst_k", datak, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_txc", tx_count, 4'd0);
      q.delete();
      m_txc = '0;
      last  = N - 1;
      req   = 2'b10;
      @(posedge clk);
      #1;
      chk("in_rst_busy", busy, 1'b0);
      reset = 1'b0;
      cycle();
      chk("post_rst_gnt", gnt, 2'b10);
      req = '0;
      repeat (21) cycle();
      chk("post_rst_txc", tx_count, 4'd1);

      // abort at byte 5
      src_tlp[0] = rnd160();
      req = 2'b01;
      cycle();
      req = '0;
      repeat (5) cycle();
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      repeat (20) cycle();

      // counter wrap with one source held
      need = (15 - int'(m_txc)) % 16;
      req  = 2'b01;
      repeat (need * 22) cycle();
      chk("wrap15", tx_count, 4'd15);
      repeat (22) cycle();
      chk("wrap0", tx_count, 4'd0);
      req = '0;
      repeat (25) cycle();

      // random traffic
      repeat (2000) begin
         abort = ($urandom_range(15, 0) == 0);
         cycle();
         upd_req();
      end
      abort = 1'b0;
      req   = '0;
      repeat (25) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
